// File: rtl/alu.sv
// 32-bit ALU with registered result/branch decision, 1-cycle latency, 1 op/cycle, no backpressure.
// Optional status flags (zero/negative/carry/overflow) are built only when ALU_FLAGS_EN is defined.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ip_0,
  input  logic [WIDTH-1:0] ip_1,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] op_0,
  output logic             change_pc,
`ifdef ALU_FLAGS_EN
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
`endif
  output logic             out_valid
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PASS = 3'd1;
  localparam logic [2:0] OP_BEQ  = 3'd2;
  localparam logic [2:0] OP_BLT  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  logic             sub_sel;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             lt;
  logic [WIDTH-1:0] res_nxt;
  logic             pc_nxt;

  // One adder serves ADD, SUB and the signed BLT compare (a - b).
  assign sub_sel = (opcode == OP_SUB) || (opcode == OP_BLT);
  assign b_op    = sub_sel ? ~ip_1 : ip_1;

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  assign sum_ext = {1'b0, ip_0} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_sel};
  assign sum     = sum_ext[WIDTH-1:0];
`else
  assign sum = ip_0 + b_op + {{(WIDTH-1){1'b0}}, sub_sel};
`endif

  assign ovf = (ip_0[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != ip_0[WIDTH-1]);
  assign lt  = sum[WIDTH-1] ^ ovf;

  always_comb begin
    res_nxt = '0;
    pc_nxt  = 1'b0;
    case (opcode)
      OP_NOP:  res_nxt = '0;
      OP_PASS: res_nxt = ip_1;
      OP_BEQ:  pc_nxt  = (ip_0 == ip_1);
      OP_BLT:  pc_nxt  = lt;
      OP_ADD:  res_nxt = sum;
      OP_SUB:  res_nxt = sum;
      OP_AND:  res_nxt = ip_0 & ip_1;
      OP_OR:   res_nxt = ip_0 | ip_1;
      default: res_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_0      <= '0;
      change_pc <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        op_0      <= res_nxt;
        change_pc <= pc_nxt;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic is_arith;
  assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (in_valid) begin
      zero     <= (res_nxt == '0);
      negative <= res_nxt[WIDTH-1];
      carry    <= is_arith & sum_ext[WIDTH];
      overflow <= is_arith & ovf;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; flag checks compile in when ALU_FLAGS_EN is defined.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] ip_0;
  logic [31:0] ip_1;
  logic [2:0]  opcode;
  logic [31:0] op_0;
  logic        change_pc;
  logic        out_valid;
`ifdef ALU_FLAGS_EN
  logic        zero, negative, carry, overflow;
`endif

  int total = 0;
  int bad   = 0;

  alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ip_0      (ip_0),
    .ip_1      (ip_1),
    .opcode    (opcode),
    .op_0      (op_0),
    .change_pc (change_pc),
`ifdef ALU_FLAGS_EN
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic vld, input logic [31:0] res, input logic pc);
    chk1({tag, ".valid"}, out_valid, vld);
    chk32({tag, ".op_0"}, op_0, res);
    chk1({tag, ".change_pc"}, change_pc, pc);
  endtask

`ifdef ALU_FLAGS_EN
  task automatic expect_flags(input string tag, input logic z, input logic n, input logic c, input logic v);
    chk1({tag, ".zero"}, zero, z);
    chk1({tag, ".negative"}, negative, n);
    chk1({tag, ".carry"}, carry, c);
    chk1({tag, ".overflow"}, overflow, v);
  endtask
`endif

  // Present one op at the falling edge, then sample 1 time unit after the capturing edge.
  task automatic step(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = opc;
    ip_0     = a;
    ip_1     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    opcode   = 3'd4;
    ip_0     = 32'h5555_5555;
    ip_1     = 32'h1111_1111;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    opcode   = 3'd0;
    ip_0     = '0;
    ip_1     = '0;
    #3;
    expect_out("reset", 1'b0, 32'h0, 1'b0);
`ifdef ALU_FLAGS_EN
    expect_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(3'd4, 32'd15, 32'd10);          expect_out("add", 1'b1, 32'd25, 1'b0);
    step(3'd5, 32'd20, 32'd10);          expect_out("sub", 1'b1, 32'd10, 1'b0);
    step(3'd5, 32'd0, 32'd1);            expect_out("sub_wrap", 1'b1, 32'hFFFF_FFFF, 1'b0);
`ifdef ALU_FLAGS_EN
    expect_flags("sub_wrap", 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    idle();                              expect_out("idle_hold", 1'b0, 32'hFFFF_FFFF, 1'b0);
    step(3'd6, 32'd5, 32'd3);            expect_out("and", 1'b1, 32'd1, 1'b0);
    step(3'd7, 32'd5, 32'd2);            expect_out("or", 1'b1, 32'd7, 1'b0);
    step(3'd1, 32'h1234, 32'hDEAD_BEEF); expect_out("pass", 1'b1, 32'hDEAD_BEEF, 1'b0);
    step(3'd0, 32'd9, 32'd9);            expect_out("nop", 1'b1, 32'h0, 1'b0);
    step(3'd2, 32'd10, 32'd10);          expect_out("beq_eq", 1'b1, 32'h0, 1'b1);
    idle();                              expect_out("idle_pc_hold", 1'b0, 32'h0, 1'b1);
    step(3'd2, 32'd10, 32'd11);          expect_out("beq_ne", 1'b1, 32'h0, 1'b0);
    step(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); expect_out("beq_ones", 1'b1, 32'h0, 1'b1);
    step(3'd3, 32'd5, 32'd10);           expect_out("blt_lt", 1'b1, 32'h0, 1'b1);
    step(3'd3, 32'd10, 32'd5);           expect_out("blt_gt", 1'b1, 32'h0, 1'b0);
    step(3'd3, 32'h8000_0000, 32'd0);    expect_out("blt_neg", 1'b1, 32'h0, 1'b1);
    step(3'd3, 32'd0, 32'h8000_0000);    expect_out("blt_pos", 1'b1, 32'h0, 1'b0);
    step(3'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFF); expect_out("blt_ovf", 1'b1, 32'h0, 1'b0);
    step(3'd2, 32'd3, 32'd3);            expect_out("beq_pre", 1'b1, 32'h0, 1'b1);
    step(3'd4, 32'h7FFF_FFFF, 32'd1);    expect_out("add_ovf", 1'b1, 32'h8000_0000, 1'b0);
`ifdef ALU_FLAGS_EN
    expect_flags("add_ovf", 1'b0, 1'b1, 1'b0, 1'b1);
`endif
    step(3'd5, 32'd7, 32'd7);            expect_out("sub_zero", 1'b1, 32'h0, 1'b0);
`ifdef ALU_FLAGS_EN
    expect_flags("sub_zero", 1'b1, 1'b0, 1'b1, 1'b0);
    step(3'd4, 32'hFFFF_FFFF, 32'd2);    expect_out("add_carry", 1'b1, 32'd1, 1'b0);
    expect_flags("add_carry", 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Four ops on consecutive cycles, sampled each cycle.
    step(3'd4, 32'd1, 32'd2);            expect_out("stream0", 1'b1, 32'd3, 1'b0);
    step(3'd7, 32'hF0, 32'h0F);          expect_out("stream1", 1'b1, 32'hFF, 1'b0);
    step(3'd3, 32'hFFFF_FFFF, 32'd1);    expect_out("stream2", 1'b1, 32'h0, 1'b1);
    step(3'd5, 32'd100, 32'd1);          expect_out("stream3", 1'b1, 32'd99, 1'b0);
    idle();                              expect_out("stream_end", 1'b0, 32'd99, 1'b0);

    // Reset asserted while an op is being presented discards it.
    step(3'd4, 32'd1, 32'd2);            expect_out("pre_rst", 1'b1, 32'd3, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 3'd4;
    ip_0     = 32'd4;
    ip_1     = 32'd4;
    #2 rst_n = 1'b0;
    #1;
    expect_out("rst_async", 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    expect_out("rst_edge", 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    expect_out("rst_release", 1'b0, 32'h0, 1'b0);
    step(3'd4, 32'd2, 32'd2);            expect_out("post_rst", 1'b1, 32'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
